div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//   Iterative radix-2 restoring divider for the RV32M divide group: DIV, DIVU, REM, REMU.
//   Completes the M-extension alongside the single-cycle multiplier and uses the same
//   5-bit ctrl bus encoding. Runs as a multi-cycle execute-stage unit:
//   start/busy/done handshake, result held in a register.
// PARAMETERS
//   XLEN   32   operand/result width; the iteration count equals XLEN
// PORTS
//   clk    in   1     single clock, rising edge
//   rst    in   1     synchronous, active-high reset
//   start  in   1     request; sampled only while accepting (state IDLE or DONE)
//   A      in   XLEN  dividend (rs1); latched on accepted start
//   B      in   XLEN  divisor (rs2); latched on accepted start
//   ctrl   in   5     op: 14=DIV 15=DIVU 16=REM 17=REMU; latched on accepted start
//   Y      out  XLEN  result register; held until the next completion
//   busy   out  1     high in CALC and FIX states
//   done   out  1     one-cycle pulse in the DONE state; Y is valid from this cycle
// BEHAVIOUR
//   - Reset: state=IDLE, Y=0, busy=0, done=0, iteration counter=0. rst mid-operation
//     aborts the operation; no done is produced for it.
//   - FSM: IDLE -start-> CALC (XLEN cycles) -> FIX (1 cycle) -> DONE (1 cycle) -> IDLE.
//     In DONE, start is accepted (back-to-back), and the next state is CALC.
//   - Latency: start high in cycle 0 -> CALC cycles 1..32 -> FIX cycle 33 -> done=1 in cycle 34.
//   - start in CALC/FIX: ignored. Operands do not change.
//   - Signed ops (DIV/REM): divide the magnitudes |A| and |B|.
//     Quotient is negated when sign(A)!=sign(B). Remainder takes the sign of A.
//     Unsigned ops use the raw operands.
//   - CALC: each cycle shifts {rem,quo} left by 1 and trial-subtracts the divisor from rem.
//     If no borrow, rem takes the difference and the quotient LSB is 1.
//     rem is XLEN+1 bits wide internally.
//   - FIX: applies sign correction and special cases, then registers Y.
//       B==0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> A.
//       DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000; the matching REM -> 0.
//   - Unlisted ctrl value with start: accepted, full latency, Y=0 (matches the multiplier default).
//   - No exceptions are raised. Results follow the RISC-V spec bit-exactly.
// CONFIGURATION
//   DIV_EARLY_OUT_EN defined:
//     - B==0 or signed overflow detected at accept goes straight to DONE; done occurs in cycle 1.
//     - busy stays low for these operations. Y carries the special-case value above.
//   DIV_EARLY_OUT_EN undefined:
//     - every operation takes exactly 34 cycles (deterministic); special cases are resolved in FIX.
// STRUCTURE
//   - Shared package riscv_m_pkg:
//     - ctrl codes: MUL=10 MULH=11 MULHU=12 MULHSU=13 DIV=14 DIVU=15 REM=16 REMU=17
//     - div FSM state typedef {IDLE, CALC, FIX, DONE}
//     - XLEN default
//   - Sub-module div_step: combinational single restoring iteration.
//     Inputs are rem, quo and divisor; outputs are the next rem and next quo.
//     Instantiated once in the CALC datapath.
// TESTING
//   1. DIVU A=100 B=7 start@0 -> busy cycles 1..33, done@34, Y=14; REMU same operands -> Y=2.
//   2. DIV A=-7 (0xFFFFFFF9) B=2 -> Y=0xFFFFFFFD (-3); REM same operands -> Y=0xFFFFFFFF (-1).
//   3. DIV A=0x80000000 B=0xFFFFFFFF -> Y=0x80000000; REM -> Y=0.
//      Done@34, or done@1 with DIV_EARLY_OUT_EN.
//   4. DIVU A=5 B=0 -> Y=0xFFFFFFFF; REMU A=5 B=0 -> Y=5; DIV A=-5 B=0 -> Y=0xFFFFFFFF.
//   5. Start DIVU 100/7; pulse start with new operands at cycle 10 -> ignored, Y=14 @34.
//      Start accepted in the DONE cycle -> second result (e.g. 50/5 -> Y=10) done@68.
//   6. Start DIVU 100/7; rst high at cycle 10 -> cycle 11: busy=0, Y=0, done never pulses.
//      Next DIVU 9/3 gives done 34 cycles after its start, Y=3.

Source files
------------

// File: rtl/riscv_m_pkg.sv
// Shared RV32M definitions: ctrl op codes, divider FSM states and default width.
package riscv_m_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [4:0] {
        OP_MUL    = 5'd10,
        OP_MULH   = 5'd11,
        OP_MULHU  = 5'd12,
        OP_MULHSU = 5'd13,
        OP_DIV    = 5'd14,
        OP_DIVU   = 5'd15,
        OP_REM    = 5'd16,
        OP_REMU   = 5'd17
    } m_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_e;

    function automatic logic is_signed_div(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_div_group(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor.
module div_step
    import riscv_m_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN:0]   i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN:0]   o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN+1:0] w_rem_sh;
    logic [XLEN+1:0] w_diff;

    assign w_rem_sh = {i_rem, i_quo[XLEN-1]};
    // The extra top bit of w_diff is the borrow of the trial subtraction.
    assign w_diff   = w_rem_sh - {2'b00, i_divisor};

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        o_rem = w_rem_sh[XLEN:0];
        o_quo = {i_quo[XLEN-2:0], 1'b0};
        if (!w_diff[XLEN+1]) begin
            o_rem    = w_diff[XLEN:0];
            o_quo[0] = 1'b1;
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with start/busy/done handshake.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish straight from accept.
module div_unit
    import riscv_m_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [4:0]      ctrl,
    output logic [XLEN-1:0] Y,
    output logic            busy,
    output logic            done
);

    localparam int            CW   = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_y;
    logic [XLEN:0]   r_rem;
    logic [XLEN-1:0] r_quo, r_div, r_a;
    logic [4:0]      r_op;
    logic            r_neg_q, r_neg_r, r_b_zero, r_ovf;

    logic            w_accept, w_early, w_a_neg, w_b_neg, w_b_zero, w_ovf;
    logic [XLEN:0]   w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt, w_quo_fix, w_rem_fix, w_fix_y;

    // Special cases override the iterated result; unlisted ops read as zero.
    function automatic logic [XLEN-1:0] result_sel(
        input logic [4:0]      op,
        input logic            b_zero,
        input logic            ovf,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] quo,
        input logic [XLEN-1:0] rem
    );
        case (op)
            OP_DIV:  return b_zero ? '1 : (ovf ? a : quo);
            OP_DIVU: return b_zero ? '1 : quo;
            OP_REM:  return b_zero ? a : (ovf ? '0 : rem);
            OP_REMU: return b_zero ? a : rem;
            default: return '0;
        endcase
    endfunction

    assign w_accept = start && (r_state == IDLE || r_state == DONE);
    assign w_a_neg  = is_signed_div(ctrl) && A[XLEN-1];
    assign w_b_neg  = is_signed_div(ctrl) && B[XLEN-1];
    assign w_b_zero = (B == '0);
    assign w_ovf    = is_signed_div(ctrl) && (A == INT_MIN) && (B == '1);

`ifdef DIV_EARLY_OUT_EN
    logic [XLEN-1:0] w_early_y;
    assign w_early   = w_accept && is_div_group(ctrl) && (w_b_zero || w_ovf);
    assign w_early_y = result_sel(ctrl, w_b_zero, w_ovf, A, '0, '0);
`else
    assign w_early   = 1'b0;
`endif

    div_step #(.XLEN(XLEN)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_div),
        .o_rem     (w_rem_nxt),
        .o_quo     (w_quo_nxt)
    );

    assign w_quo_fix = r_neg_q ? -r_quo : r_quo;
    assign w_rem_fix = r_neg_r ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
    assign w_fix_y   = result_sel(r_op, r_b_zero, r_ovf, r_a, w_quo_fix, w_rem_fix);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept)
                    w_next = w_early ? DONE : CALC;
                else
                    w_next = IDLE;
            end
            CALC:    if (r_cnt == LAST) w_next = FIX;
            FIX:     w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept)
                r_cnt <= '0;
            else if (r_state == CALC)
                r_cnt <= r_cnt + 1'b1;
            if (r_state == FIX)
                r_y <= w_fix_y;
`ifdef DIV_EARLY_OUT_EN
            if (w_early)
                r_y <= w_early_y;
`endif
        end
    end

    // NOTE: the datapath is loaded on every accept, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op     <= ctrl;
            r_a      <= A;
            r_rem    <= '0;
            r_quo    <= w_a_neg ? -A : A;
            r_div    <= w_b_neg ? -B : B;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_b_zero <= w_b_zero;
            r_ovf    <= w_ovf;
        end else if (r_state == CALC) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
        end
    end

    assign Y    = r_y;
    assign busy = (r_state == CALC) || (r_state == FIX);
    assign done = (r_state == DONE);

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: random and directed ops against an arithmetic reference model.
module tb_div_unit;

    localparam logic [4:0] C_DIV  = 5'd14;
    localparam logic [4:0] C_DIVU = 5'd15;
    localparam logic [4:0] C_REM  = 5'd16;
    localparam logic [4:0] C_REMU = 5'd17;

    logic        clk = 1'b0;
    logic        rst, start, busy, done;
    logic [31:0] A, B, Y;
    logic [4:0]  ctrl;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] y;
        int          due;
    } exp_t;

    exp_t exp_q[$];

    div_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .ctrl  (ctrl),
        .Y     (Y),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, req, cyc);
    endtask

    // RISC-V M semantics with plain integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int  sa, sb;
        bit  ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            C_DIV:   return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
            C_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            C_REM:   return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
            C_REMU:  return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        bit div_op, sgn;
        div_op = (op >= C_DIV) && (op <= C_REMU);
        sgn    = (op == C_DIV) || (op == C_REM);
        if (div_op && ((b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
`endif
        return 34;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        start = 1'b1;
        ctrl  = op;
        A     = a;
        B     = b;
        e.y   = ref_model(op, a, b);
        e.due = cyc + latency(op, a, b);
        exp_q.push_back(e);
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 200 && exp_q.size() != 0; t++)
            step();
        if (exp_q.size() != 0) begin
            check("done_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result_y", Y, e.y);
                check("done_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        logic [4:0]  op;
        logic [31:0] a, b;

        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        ctrl  = '0;
        repeat (2) step();
        check("reset_y", Y, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        step();

        // Busy profile of a full-latency operation.
        c0 = cyc;
        issue(C_DIVU, 32'd100, 32'd7);
        while (cyc <= c0 + 35) begin
            check("busy_profile", {31'd0, busy}, {31'd0, (cyc - c0 >= 1) && (cyc - c0 <= 33)});
            step();
        end
        wait_idle();

        issue(C_REMU, 32'd100, 32'd7);                   wait_idle();
        issue(C_DIV,  32'hFFFF_FFF9, 32'd2);             wait_idle();
        issue(C_REM,  32'hFFFF_FFF9, 32'd2);             wait_idle();
        issue(C_DIV,  32'h8000_0000, 32'hFFFF_FFFF);     wait_idle();
        issue(C_REM,  32'h8000_0000, 32'hFFFF_FFFF);     wait_idle();
        issue(C_DIVU, 32'd5, 32'd0);                     wait_idle();
        issue(C_REMU, 32'd5, 32'd0);                     wait_idle();
        issue(C_DIV,  32'hFFFF_FFFB, 32'd0);             wait_idle();
        issue(C_REM,  32'hFFFF_FFFB, 32'd0);             wait_idle();
        issue(C_DIVU, 32'hFFFF_FFFF, 32'd1);             wait_idle();
        issue(5'd11,  32'd100, 32'd7);                   wait_idle();

        // Start during CALC is ignored; start in the DONE cycle is taken back-to-back.
        c0 = cyc;
        issue(C_DIVU, 32'd100, 32'd7);
        while (cyc < c0 + 10) step();
        start = 1'b1;
        ctrl  = C_DIVU;
        A     = 32'd3;
        B     = 32'd1;
        step();
        start = 1'b0;
        while (cyc < c0 + 34) step();
        issue(C_DIVU, 32'd50, 32'd5);
        wait_idle();

        // Reset mid-operation aborts it without a done pulse.
        c0 = cyc;
        issue(C_DIVU, 32'd100, 32'd7);
        while (cyc < c0 + 10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_y", Y, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        repeat (40) step();
        issue(C_DIVU, 32'd9, 32'd3);
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            op = 5'(C_DIV + $urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0)
                op = 5'($urandom_range(0, 13));
            a = $urandom();
            b = $urandom();
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       b = 32'($urandom_range(1, 15));
                3:       b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            issue(op, a, b);
            wait_idle();
        end

        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
